// File: rtl/lsu_pkg.sv
// Shared constants, FSM state type and legality checks for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned MASK_W = 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } lsu_state_t;

    // Encoding check only: stores allow B/H/W, loads additionally BU/HU.
    function automatic logic f3_legal(input logic wen, input logic [2:0] funct3);
        if (wen) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // Natural alignment of the access size; only the low address bits matter.
    function automatic logic is_aligned(input logic [2:0] funct3, input logic [1:0] addr);
        case (funct3)
            F3_H, F3_HU: return ~addr[0];
            F3_W:        return addr == 2'b00;
            default:     return 1'b1;
        endcase
    endfunction

    // Full legality: valid encoding and naturally aligned.
    function automatic logic is_legal(input logic wen, input logic [2:0] funct3,
                                      input logic [1:0] addr);
        return f3_legal(wen, funct3) && is_aligned(funct3, addr);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data shift and load extract/extend.
module lsu_align
    import lsu_pkg::*;
#(
    parameter bit WRAP = 1'b0
) (
    input  logic [2:0]        funct3,
    input  logic [1:0]        sh,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [MASK_W-1:0] mask,
    output logic [XLEN-1:0]   wdata_sh,
    output logic [XLEN-1:0]   rdata_ext
);

    logic [4:0]      bit_sh;
    logic [5:0]      bit_sh_inv;
    logic [3:0]      lanes;
    logic [7:0]      lanes_sh;
    logic [XLEN-1:0] w;

    assign bit_sh     = {sh, 3'b000};
    assign bit_sh_inv = 6'd32 - {1'b0, bit_sh};

    // Lanes touched by the access size before shifting.
    always_comb begin
        lanes = 4'b1111;
        case (funct3[1:0])
            2'b00:   lanes = 4'b0001;
            2'b01:   lanes = 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // Lanes that spill past byte 3 fold back to the bottom of the word.
    assign lanes_sh = {4'b0000, lanes} << sh;
    assign mask     = {4'b0000, lanes_sh[3:0] | lanes_sh[7:4]};

    // Plain shifts for aligned use; rotates when misaligned lanes must wrap.
    assign wdata_sh = WRAP ? ((wdata << bit_sh) | (wdata >> bit_sh_inv)) : (wdata << bit_sh);
    assign w        = WRAP ? ((rdata >> bit_sh) | (rdata << bit_sh_inv)) : (rdata >> bit_sh);

    // Select and sign/zero extend the loaded field.
    always_comb begin
        rdata_ext = '0;
        case (funct3)
            F3_B:    rdata_ext = {{24{w[7]}}, w[7:0]};
            F3_H:    rdata_ext = {{16{w[15]}}, w[15:0]};
            F3_W:    rdata_ext = w;
            F3_BU:   rdata_ext = {24'h000000, w[7:0]};
            F3_HU:   rdata_ext = {16'h0000, w[15:0]};
            default: rdata_ext = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one transaction at a time from EXU to data memory and back to WBU.
module lsu
    import lsu_pkg::*;
#(
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wen,
    input  logic [2:0]        in_funct3,
    input  logic [XLEN-1:0]   in_addr,
    input  logic [XLEN-1:0]   in_wdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_rdata,
    output logic              out_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [XLEN-1:0]   mem_raddr,
    output logic [XLEN-1:0]   mem_waddr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_mask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    lsu_state_t        state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        sh_q, sh_d;
    logic              in_ready_d;
    logic              mem_ren_d, mem_wen_d;
    logic [XLEN-1:0]   mem_raddr_d, mem_waddr_d, mem_wdata_d;
    logic [MASK_W-1:0] mem_mask_d;
    logic              out_valid_d, out_err_d;
    logic [XLEN-1:0]   out_rdata_d;

    logic              legal;
    logic [XLEN-1:0]   word_addr;
    logic [2:0]        al_f3;
    logic [1:0]        al_sh;
    logic [MASK_W-1:0] al_mask;
    logic [XLEN-1:0]   al_wdata, al_rdata;

    assign legal = ALIGN_CHECK ? is_legal(in_wen, in_funct3, in_addr[1:0])
                               : f3_legal(in_wen, in_funct3);
    assign word_addr = {in_addr[XLEN-1:2], 2'b00};

    // Aligner sees the incoming request while idle (store encoding), latched fields afterwards (load decode).
    assign al_f3 = (state_q == IDLE) ? in_funct3    : f3_q;
    assign al_sh = (state_q == IDLE) ? in_addr[1:0] : sh_q;

    lsu_align #(
        .WRAP (~ALIGN_CHECK)
    ) u_align (
        .funct3    (al_f3),
        .sh        (al_sh),
        .wdata     (in_wdata),
        .rdata     (mem_rdata),
        .mask      (al_mask),
        .wdata_sh  (al_wdata),
        .rdata_ext (al_rdata)
    );

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            wen_q     <= 1'b0;
            f3_q      <= 3'b000;
            sh_q      <= 2'b00;
            in_ready  <= 1'b0;
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_raddr <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            mem_mask  <= '0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_rdata <= '0;
        end else begin
            state_q   <= state_d;
            wen_q     <= wen_d;
            f3_q      <= f3_d;
            sh_q      <= sh_d;
            in_ready  <= in_ready_d;
            mem_ren   <= mem_ren_d;
            mem_wen   <= mem_wen_d;
            mem_raddr <= mem_raddr_d;
            mem_waddr <= mem_waddr_d;
            mem_wdata <= mem_wdata_d;
            mem_mask  <= mem_mask_d;
            out_valid <= out_valid_d;
            out_err   <= out_err_d;
            out_rdata <= out_rdata_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        f3_d        = f3_q;
        sh_d        = sh_q;
        in_ready_d  = in_ready;
        mem_ren_d   = mem_ren;
        mem_wen_d   = mem_wen;
        mem_raddr_d = mem_raddr;
        mem_waddr_d = mem_waddr;
        mem_wdata_d = mem_wdata;
        mem_mask_d  = mem_mask;
        out_valid_d = out_valid;
        out_err_d   = out_err;
        out_rdata_d = out_rdata;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    wen_d      = in_wen;
                    f3_d       = in_funct3;
                    sh_d       = in_addr[1:0];
                    in_ready_d = 1'b0;
                    if (legal) begin
                        state_d     = REQ;
                        mem_ren_d   = ~in_wen;
                        mem_wen_d   = in_wen;
                        mem_raddr_d = in_wen ? '0 : word_addr;
                        mem_waddr_d = in_wen ? word_addr : '0;
                        mem_wdata_d = in_wen ? al_wdata : '0;
                        mem_mask_d  = in_wen ? al_mask : '0;
                    end else begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b1;
                        out_rdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    mem_ren_d = 1'b0;
                    mem_wen_d = 1'b0;
                    if (mem_rvalid) begin
                        state_d     = RESP;
                        out_valid_d = 1'b1;
                        out_err_d   = 1'b0;
                        out_rdata_d = wen_q ? '0 : al_rdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    state_d     = RESP;
                    out_valid_d = 1'b1;
                    out_err_d   = 1'b0;
                    out_rdata_d = wen_q ? '0 : al_rdata;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    in_ready_d  = 1'b1;
                    out_valid_d = 1'b0;
                    out_err_d   = 1'b0;
                    out_rdata_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized transactions against a byte-level model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_wen = 1'b0;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_addr = 32'h0;
    logic [31:0] in_wdata = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_rdata;
    logic        out_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_raddr;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int tests = 0;
    int fails = 0;

    lsu #(.ALIGN_CHECK(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_wen     (in_wen),
        .in_funct3  (in_funct3),
        .in_addr    (in_addr),
        .in_wdata   (in_wdata),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_rdata  (out_rdata),
        .out_err    (out_err),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_raddr  (mem_raddr),
        .mem_waddr  (mem_waddr),
        .mem_wdata  (mem_wdata),
        .mem_mask   (mem_mask),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: access size in bytes.
    function automatic int m_size(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            default:    return 4;
        endcase
    endfunction

    function automatic bit m_legal(input logic wen, input logic [2:0] f3, input logic [31:0] a);
        bit ok;
        if (wen) ok = (f3 <= 3'd2);
        else     ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return ok && ((int'(a % 32'd4) % m_size(f3)) == 0);
    endfunction

    // Assemble the loaded value byte by byte, then sign-extend arithmetically.
    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
        int          sz;
        int          sh;
        longint      v;
        logic [7:0]  b [4];
        sz = m_size(f3);
        sh = int'(a % 32'd4);
        v  = 0;
        for (int i = 0; i < 4; i++) b[i] = rd[8*i +: 8];
        for (int i = 0; i < sz; i++) v += longint'(b[sh + i]) << (8 * i);
        if ((f3 == 3'd0 || f3 == 3'd1) && v >= (longint'(1) << (8 * sz - 1)))
            v -= longint'(1) << (8 * sz);
        return 32'(v);
    endfunction

    function automatic logic [7:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] m;
        int         sh;
        m  = 8'h00;
        sh = int'(a % 32'd4);
        for (int i = 0; i < m_size(f3); i++) m[sh + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [31:0] a);
        return wd << (8 * int'(a % 32'd4));
    endfunction

    // Memory-side outputs expected throughout the REQ state.
    task automatic check_req(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd);
        logic [31:0] wa;
        wa = a - (a % 32'd4);
        check("req_ren", 32'(mem_ren), 32'(!wen));
        check("req_wen", 32'(mem_wen), 32'(wen));
        if (wen) begin
            check("req_waddr", mem_waddr, wa);
            check("req_mask", 32'(mem_mask), 32'(m_mask(f3, a)));
            check("req_wdata", mem_wdata, m_wdata(wd, a));
        end else begin
            check("req_raddr", mem_raddr, wa);
        end
        check("req_out_valid", 32'(out_valid), 32'd0);
    endtask

    // One complete transaction: rlat cycles of mem_ready low, rvalid vlat cycles after
    // acceptance, olat cycles of WBU back-pressure.
    task automatic do_txn(input logic wen, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int rlat, input int vlat, input int olat);
        bit          legal;
        logic [31:0] exp_rd;
        legal  = m_legal(wen, f3, a);
        exp_rd = 32'h0;
        if (!wen && legal) exp_rd = m_load(f3, a, rd);

        check("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        in_wen    = wen;
        in_funct3 = f3;
        in_addr   = a;
        in_wdata  = wd;
        mem_ready = 1'b0;
        mem_rvalid = 1'b0;
        tick();
        in_valid  = 1'b0;
        in_wen    = 1'($urandom);
        in_funct3 = 3'($urandom);
        in_addr   = $urandom;
        in_wdata  = $urandom;
        check("busy_in_ready", 32'(in_ready), 32'd0);

        if (legal) begin
            check_req(wen, f3, a, wd);
            for (int k = 0; k < rlat; k++) begin
                mem_ready  = 1'b0;
                mem_rvalid = 1'($urandom);
                mem_rdata  = $urandom;
                tick();
                check_req(wen, f3, a, wd);
            end
            mem_ready  = 1'b1;
            mem_rvalid = (vlat == 0);
            mem_rdata  = (vlat == 0) ? rd : $urandom;
            tick();
            mem_ready  = 1'b0;
            mem_rvalid = 1'b0;
            for (int i = 1; i <= vlat; i++) begin
                check("wait_ren", 32'(mem_ren), 32'd0);
                check("wait_wen", 32'(mem_wen), 32'd0);
                check("wait_out_valid", 32'(out_valid), 32'd0);
                mem_rvalid = (i == vlat);
                mem_rdata  = (i == vlat) ? rd : $urandom;
                tick();
                mem_rvalid = 1'b0;
            end
        end

        check("resp_out_valid", 32'(out_valid), 32'd1);
        check("resp_out_err", 32'(out_err), 32'(!legal));
        check("resp_out_rdata", out_rdata, exp_rd);
        check("resp_mem_ren", 32'(mem_ren), 32'd0);
        check("resp_mem_wen", 32'(mem_wen), 32'd0);
        for (int k = 0; k < olat; k++) begin
            out_ready  = 1'b0;
            mem_rvalid = 1'($urandom);
            mem_rdata  = $urandom;
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_rdata", out_rdata, exp_rd);
        end
        mem_rvalid = 1'b0;
        out_ready  = 1'b1;
        tick();
        out_ready = 1'b0;
        check("done_out_valid", 32'(out_valid), 32'd0);
        check("done_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [2:0]  f3;
        logic        wen;
        logic [31:0] a;

        // Power-on reset.
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_mem_ren", 32'(mem_ren), 32'd0);
        check("rst_mem_wen", 32'(mem_wen), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_hold_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed cases.
        do_txn(1'b1, 3'd2, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0);
        do_txn(1'b0, 3'd0, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        do_txn(1'b0, 3'd4, 32'h8000_0003, 32'h0, 32'h80FF_1234, 0, 0, 0);
        do_txn(1'b0, 3'd5, 32'h8000_0002, 32'h0, 32'h80FF_1234, 0, 0, 0);
        do_txn(1'b1, 3'd1, 32'h8000_0002, 32'h0000_ABCD, 32'h0, 0, 0, 1);
        do_txn(1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h1234_5678, 0, 0, 0);
        do_txn(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, 0, 0);
        do_txn(1'b1, 3'd4, 32'h8000_0000, 32'h1111_2222, 32'h0, 0, 0, 0);
        do_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 3, 2, 4);

        // Stray response while idle is dropped.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_AAAA;
        tick();
        mem_rvalid = 1'b0;
        check("stray_out_valid", 32'(out_valid), 32'd0);
        check("stray_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset while waiting for a read response.
        in_valid  = 1'b1;
        in_wen    = 1'b0;
        in_funct3 = 3'd2;
        in_addr   = 32'h8000_0020;
        tick();
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        check("pre_rst_wait_ren", 32'(mem_ren), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_mem_raddr", mem_raddr, 32'h0);
        check("arst_out_rdata", out_rdata, 32'h0);
        check("arst_out_err", 32'(out_err), 32'd0);
        tick();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h7777_7777;
        tick();
        mem_rvalid = 1'b0;
        check("late_rvalid_out_valid", 32'(out_valid), 32'd0);
        check("arst_release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("late_rvalid_out_valid2", 32'(out_valid), 32'd0);

        // Randomized transactions.
        for (int n = 0; n < 60; n++) begin
            wen = 1'($urandom);
            f3  = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'd0;
                    1: f3 = 3'd1;
                    2: f3 = 3'd2;
                    3: f3 = wen ? 3'd0 : 3'd4;
                    default: f3 = wen ? 3'd1 : 3'd5;
                endcase
            end
            a = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            do_txn(wen, f3, a, $urandom, $urandom,
                   $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
